// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin over WIDTH bits, one nibble per clock.
// Borrow is carried between nibbles in a register instead of a wide chain.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [IW+1:0]    base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       step;
  logic [WIDTH-1:0] diff_nxt;

  always_comb begin
    base     = {idx_q, 2'b00};
    a_nib    = a_q[base +: 4];
    b_nib    = b_q[base +: 4];
    // 5-bit difference: bit 4 is the borrow into the next nibble
    step     = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, br_q};
    diff_nxt = diff_q;
    diff_nxt[base +: 4] = step[3:0];

    state_d = state_q;
    idx_d   = idx_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        diff_d = diff_nxt;
        br_d   = step[4];
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_DONE;
          idx_d   = '0;
          bout_d  = step[4];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (diff_nxt == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor at WIDTH=16 and WIDTH=8,
// checked against an arithmetic reference model.
module tb_nibble_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s16, bi16, s8, bi8;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic        busy16, done16, bout16, ovf16, zero16;
  logic        busy8, done8, bout8, ovf8, zero8;
  logic [15:0] diff16;
  logic [7:0]  diff8;

  int vectors = 0;
  int miscompares = 0;

  nibble_serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .bin(bi16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16),
    .ovf(ovf16), .zero(zero16)
  );

  nibble_serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8),
    .ovf(ovf8), .zero(zero8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w8, input bit s, input logic [15:0] a,
                       input logic [15:0] b, input bit bi);
    if (w8) begin
      s8 = s; a8 = a[7:0]; b8 = b[7:0]; bi8 = bi;
    end else begin
      s16 = s; a16 = a; b16 = b; bi16 = bi;
    end
  endtask

  function automatic logic busy_of(input bit w8);
    return w8 ? busy8 : busy16;
  endfunction

  function automatic logic done_of(input bit w8);
    return w8 ? done8 : done16;
  endfunction

  task automatic wait_done(input bit w8, output int cyc);
    cyc = 0;
    while (!done_of(w8) && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic check_result(input bit w8, input string tag,
                              input logic [15:0] a, input logic [15:0] b,
                              input bit bi);
    int     w;
    longint mask, half, ua, ub, d, sa, sb, sd;
    logic [15:0] ediff;
    logic   ebout, eovf, ezero;
    w     = w8 ? 8 : 16;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    ua    = longint'(a) & mask;
    ub    = longint'(b) & mask;
    d     = ua - ub - longint'(bi);
    ediff = 16'(d & mask);
    ebout = (d < 0);
    sa    = (ua >= half) ? ua - 2 * half : ua;
    sb    = (ub >= half) ? ub - 2 * half : ub;
    sd    = sa - sb - longint'(bi);
    eovf  = (sd < -half) || (sd >= half);
    ezero = (ediff == 16'h0);
    if (w8) begin
      chk({tag, "_diff"}, {24'h0, diff8}, {16'h0, ediff});
      chk({tag, "_bout"}, bout8, ebout);
      chk({tag, "_ovf"}, ovf8, eovf);
      chk({tag, "_zero"}, zero8, ezero);
    end else begin
      chk({tag, "_diff"}, diff16, ediff);
      chk({tag, "_bout"}, bout16, ebout);
      chk({tag, "_ovf"}, ovf16, eovf);
      chk({tag, "_zero"}, zero16, ezero);
    end
  endtask

  task automatic op(input bit w8, input string tag, input logic [15:0] a,
                    input logic [15:0] b, input bit bi);
    int cyc;
    int n;
    n = w8 ? 2 : 4;
    drive(w8, 1'b1, a, b, bi);
    step();
    chk({tag, "_busy"}, busy_of(w8), 1);
    drive(w8, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    wait_done(w8, cyc);
    chk({tag, "_lat"}, cyc, n);
    check_result(w8, tag, a, b, bi);
    step();
    chk({tag, "_pulse"}, done_of(w8), 0);
    chk({tag, "_idle"}, busy_of(w8), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy16"}, busy16, 0);
    chk({tag, "_done16"}, done16, 0);
    chk({tag, "_diff16"}, diff16, 0);
    chk({tag, "_bout16"}, bout16, 0);
    chk({tag, "_ovf16"}, ovf16, 0);
    chk({tag, "_zero16"}, zero16, 1);
    chk({tag, "_diff8"}, {24'h0, diff8}, 0);
    chk({tag, "_zero8"}, zero8, 1);
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b1;
    s16 = 1'b1; a16 = 16'h1234; b16 = 16'h0001; bi16 = 1'b0;
    s8 = 1'b1; a8 = 8'h12; b8 = 8'h01; bi8 = 1'b0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    s16 = 1'b0;
    s8 = 1'b0;
    step();
    chk_reset("reset_hold");

    op(0, "basic", 16'h1234, 16'h0235, 1'b0);
    chk("basic_const", diff16, 16'h0FFF);
    op(0, "wrap", 16'h0000, 16'h0001, 1'b0);
    chk("wrap_const", {diff16, 15'h0, bout16}, {16'hFFFF, 16'h0001});
    op(0, "eqbin", 16'hFFFF, 16'hFFFF, 1'b1);
    chk("eqbin_const", {diff16, 14'h0, bout16, zero16}, {16'hFFFF, 16'h0002});
    op(0, "ovf", 16'h8000, 16'h0001, 1'b0);
    chk("ovf_const", {diff16, 14'h0, ovf16, bout16}, {16'h7FFF, 16'h0002});
    op(0, "zero", 16'h5A5A, 16'h5A5A, 1'b0);
    chk("zero_const", {diff16, 15'h0, zero16}, {16'h0000, 16'h0001});
    op(1, "w8_ovf", 16'h0080, 16'h0001, 1'b0);
    op(1, "w8_wrap", 16'h0000, 16'h0001, 1'b1);

    // start pulsed while busy, then held through DONE for back-to-back
    drive(0, 1'b1, 16'h0010, 16'h0001, 1'b0);
    step();
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step();
    drive(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(0, cyc);
    chk("busy_start_lat", cyc, 3);
    check_result(0, "busy_start", 16'h0010, 16'h0001, 1'b0);
    chk("busy_start_const", diff16, 16'h000F);
    step();
    chk("b2b_busy", busy16, 1);
    chk("b2b_done", done16, 0);
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    wait_done(0, cyc);
    chk("b2b_lat", cyc, 4);
    check_result(0, "b2b", 16'hFFFF, 16'h0001, 1'b0);
    step();
    chk("b2b_pulse", done16, 0);

    // reset in the middle of a run
    drive(0, 1'b1, 16'h1234, 16'h0001, 1'b0);
    step();
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("midrst");
    seen = 0;
    repeat (8) begin
      step();
      if (done16) seen++;
    end
    chk("midrst_nodone", seen, 0);
    op(0, "after_rst", 16'hABCD, 16'h1234, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      op(0, "rnd16", 16'($urandom), 16'($urandom), 1'($urandom));
      op(1, "rnd8", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
